frame_proc_ctrl: RTL and testbench

FRAME_PROC_CTRL -- requirements
Module: frame_proc_ctrl

---
 rtl/frame_proc_ctrl_pkg.sv | 27 ++
 rtl/frame_proc_ctrl_pix_classifier.sv | 42 ++++
 rtl/frame_proc_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_frame_proc_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_proc_ctrl_pkg.sv
// Shared definitions for the frame processing controller: geometry defaults,
// colour result codes and FSM state encoding.
package frame_proc_ctrl_pkg;

  localparam int IMG_W = 160;
  localparam int IMG_H = 120;
  localparam int AW    = 15;
  localparam int DW    = 12;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    RED   = 2'b01,
    GREEN = 2'b10,
    BLUE  = 2'b11
  } color_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_VS1 = 3'd1,
    WAIT_VS2 = 3'd2,
    SCAN     = 3'd3,
    DRAIN    = 3'd4,
    DECIDE   = 3'd5,
    DONE     = 3'd6
  } state_t;

endpackage

// File: rtl/frame_proc_ctrl_pix_classifier.sv
// Classifies one RGB pixel as dominant red, green or blue against a
// per-channel threshold; the one-hot result is registered.
module pix_classifier #(
  parameter int         DATA_W = frame_proc_ctrl_pkg::DW,
  parameter logic [3:0] TH     = 4'd8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_p0,
  input  logic [DATA_W-1:0] pix_p0,
  output logic              vld_p1,
  output logic              red_p1,
  output logic              green_p1,
  output logic              blue_p1
);

  localparam int CW = DATA_W / 3;
  localparam logic [CW-1:0] TH_C = CW'(TH);

  function automatic logic chan_on(input logic [CW-1:0] c);
    return c >= TH_C;
  endfunction

  logic r_on, g_on, b_on;

  assign r_on = chan_on(pix_p0[3*CW-1:2*CW]);
  assign g_on = chan_on(pix_p0[2*CW-1:CW]);
  assign b_on = chan_on(pix_p0[CW-1:0]);

  // p0 -> p1: only the valid flag is reset; flags are ignored while it is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_p1 <= 1'b0;
    else      vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    red_p1   <=  r_on && !g_on && !b_on;
    green_p1 <= !r_on &&  g_on && !b_on;
    blue_p1  <= !r_on && !g_on &&  b_on;
  end

endmodule

// File: rtl/frame_proc_ctrl.sv
// Freezes the camera frame buffer between two VSYNC edges, scans it once,
// and reports the dominant colour through a 4-phase start/done handshake.
module frame_proc_ctrl #(
  parameter int          IMG_W       = frame_proc_ctrl_pkg::IMG_W,
  parameter int          IMG_H       = frame_proc_ctrl_pkg::IMG_H,
  parameter int          AW          = frame_proc_ctrl_pkg::AW,
  parameter int          DW          = frame_proc_ctrl_pkg::DW,
  parameter logic [3:0]  TH          = 4'd8,
  parameter logic [14:0] MIN_COUNT   = 15'd200,
  parameter logic [23:0] TIMEOUT_CYC = 24'd10_000_000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          cam_vsync,
  output logic          cam_wr_en,
  output logic [AW-1:0] scan_addr,
  output logic          scan_rd,
  input  logic [DW-1:0] pix_data,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [1:0]    color
);
  import frame_proc_ctrl_pkg::*;

  localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);
  localparam logic [23:0]   TO_LAST   = TIMEOUT_CYC - 24'd1;

  state_t      state, state_n;
  logic        vs_s1, vs_s2, vs_d, vs_rise;
  logic [23:0] to_cnt;
  logic        to_hit;
  logic        pix_vld_p0, cls_vld_p1, red_p1, green_p1, blue_p1;
  logic [14:0] cnt_r, cnt_g, cnt_b, cnt_r_n, cnt_g_n, cnt_b_n;
  color_t      best;
  logic [14:0] best_cnt;

  function automatic logic [14:0] sat_inc(input logic [14:0] v, input logic en);
    return (en && v != 15'h7FFF) ? v + 15'd1 : v;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_s1 <= 1'b0;
      vs_s2 <= 1'b0;
      vs_d  <= 1'b0;
    end else begin
      vs_s1 <= cam_vsync;
      vs_s2 <= vs_s1;
      vs_d  <= vs_s2;
    end
  end

  assign vs_rise = vs_s2 && !vs_d;
  assign to_hit  = (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n   = state;
    busy      = 1'b1;
    done      = 1'b0;
    scan_rd   = 1'b0;
    cam_wr_en = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_n = WAIT_VS1;
      end
      WAIT_VS1: begin
        if (vs_rise)     state_n = WAIT_VS2;
        else if (to_hit) state_n = DONE;
      end
      WAIT_VS2: begin
        if (vs_rise)     state_n = SCAN;
        else if (to_hit) state_n = DONE;
      end
      SCAN: begin
        scan_rd   = 1'b1;
        cam_wr_en = 1'b0;
        if (scan_addr == LAST_ADDR) state_n = DRAIN;
      end
      DRAIN: begin
        cam_wr_en = 1'b0;
        state_n   = DECIDE;
      end
      DECIDE: state_n = DONE;
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (!start) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // read data returns one cycle after scan_rd
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pix_vld_p0 <= 1'b0;
    else      pix_vld_p0 <= scan_rd;
  end

  pix_classifier #(
    .DATA_W (DW),
    .TH     (TH)
  ) u_cls (
    .clk      (clk),
    .rst      (rst),
    .vld_p0   (pix_vld_p0),
    .pix_p0   (pix_data),
    .vld_p1   (cls_vld_p1),
    .red_p1   (red_p1),
    .green_p1 (green_p1),
    .blue_p1  (blue_p1)
  );

  // the last pixel lands during DECIDE, so the decision uses next-state counts
  assign cnt_r_n = sat_inc(cnt_r, cls_vld_p1 && red_p1);
  assign cnt_g_n = sat_inc(cnt_g, cls_vld_p1 && green_p1);
  assign cnt_b_n = sat_inc(cnt_b, cls_vld_p1 && blue_p1);

  always_comb begin
    best     = RED;
    best_cnt = cnt_r_n;
    if (cnt_g_n > best_cnt) begin
      best     = GREEN;
      best_cnt = cnt_g_n;
    end
    if (cnt_b_n > best_cnt) begin
      best     = BLUE;
      best_cnt = cnt_b_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt    <= '0;
      scan_addr <= '0;
      cnt_r     <= '0;
      cnt_g     <= '0;
      cnt_b     <= '0;
      color     <= NONE;
      timeout   <= 1'b0;
    end else begin
      cnt_r <= cnt_r_n;
      cnt_g <= cnt_g_n;
      cnt_b <= cnt_b_n;
      case (state)
        IDLE: begin
          if (start) begin
            to_cnt  <= '0;
            cnt_r   <= '0;
            cnt_g   <= '0;
            cnt_b   <= '0;
            color   <= NONE;
            timeout <= 1'b0;
          end
        end
        WAIT_VS1, WAIT_VS2: begin
          if (vs_rise) begin
            to_cnt <= '0;
          end else if (to_hit) begin
            timeout <= 1'b1;
            color   <= NONE;
          end else begin
            to_cnt <= to_cnt + 24'd1;
          end
        end
        SCAN: scan_addr <= (scan_addr == LAST_ADDR) ? '0 : scan_addr + AW'(1);
        DECIDE: color <= (best_cnt >= MIN_COUNT) ? best : NONE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_proc_ctrl.sv
// Bench for frame_proc_ctrl: a full-size instance for the long scans and
// reset abort, a small-frame instance with a short timeout for colour tables.
module tb_frame_proc_ctrl;

  localparam int N_A = 19200;
  localparam int N_B = 640;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_s[2], vsync_s[2], wr_s[2], rd_s[2], busy_s[2], done_s[2], to_s[2];
  logic [14:0] addr_s[2];
  logic [11:0] pix_s[2];
  logic [1:0]  color_s[2];

  always #5 clk = ~clk;

  frame_proc_ctrl dut_a (
    .clk(clk), .rst(rst), .start(start_s[0]), .cam_vsync(vsync_s[0]),
    .cam_wr_en(wr_s[0]), .scan_addr(addr_s[0]), .scan_rd(rd_s[0]),
    .pix_data(pix_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .timeout(to_s[0]), .color(color_s[0])
  );

  frame_proc_ctrl #(.IMG_W(32), .IMG_H(20), .TIMEOUT_CYC(24'd1000)) dut_b (
    .clk(clk), .rst(rst), .start(start_s[1]), .cam_vsync(vsync_s[1]),
    .cam_wr_en(wr_s[1]), .scan_addr(addr_s[1]), .scan_rd(rd_s[1]),
    .pix_data(pix_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .timeout(to_s[1]), .color(color_s[1])
  );

  // frame contents: red block, then green, then blue, then fill
  int          n_r[2], n_g[2], n_b[2];
  logic [11:0] fill[2];

  function automatic logic [11:0] pix_of(input int d, input int a);
    if (a < n_r[d])                 return 12'hF00;
    if (a < n_r[d] + n_g[d])        return 12'h0F0;
    if (a < n_r[d] + n_g[d] + n_b[d]) return 12'h00F;
    return fill[d];
  endfunction

  always @(posedge clk) begin
    pix_s[0] <= rd_s[0] ? pix_of(0, int'(addr_s[0])) : 12'h000;
    pix_s[1] <= rd_s[1] ? pix_of(1, int'(addr_s[1])) : 12'h000;
  end

  // scan monitor: counts reads, checks address order and frozen writes
  int          scan_cnt[2], addr_err[2], wr_err[2];
  logic        prev_rd[2];
  logic [14:0] prev_addr[2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      scan_cnt[d] = 0; addr_err[d] = 0; wr_err[d] = 0;
      prev_rd[d] = 1'b0; prev_addr[d] = '0;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rd_s[d]) begin
        if (prev_rd[d] ? (addr_s[d] != prev_addr[d] + 15'd1) : (addr_s[d] != 15'd0))
          addr_err[d]++;
        if (wr_s[d] !== 1'b0) wr_err[d]++;
        scan_cnt[d]++;
      end
      prev_rd[d]   = rd_s[d];
      prev_addr[d] = addr_s[d];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int         d;
    logic [1:0] color;
    logic       to;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          n_r, n_g, n_b;
    logic [11:0] fill;
    logic [1:0]  color;
    bit          toggle;
    int          hold;
  } vec_t;
  vec_t vecs[11];

  task automatic vs_pulse(input int d);
    vsync_s[d] = 1'b1;
    repeat (4) @(negedge clk);
    vsync_s[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int limit, output int cyc);
    cyc = 0;
    while (done_s[d] !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic finish_handshake(input int d, input int hold, input string tag);
    repeat (hold) @(negedge clk);
    check({tag, " done held"}, int'(done_s[d]), 1);
    check({tag, " no restart"}, int'(busy_s[d]), 0);
    start_s[d] = 1'b0;
    @(negedge clk);
    check({tag, " done fall"}, int'(done_s[d]), 0);
  endtask

  task automatic run_frame(input int d, input int gap, input bit toggle,
                           input int hold, input string tag);
    int   base_cnt, base_aerr, base_werr, cyc, n_pix;
    exp_t e;
    n_pix     = (d == 0) ? N_A : N_B;
    base_cnt  = scan_cnt[d];
    base_aerr = addr_err[d];
    base_werr = wr_err[d];
    @(negedge clk);
    start_s[d] = 1'b1;
    repeat (5) @(negedge clk);
    vs_pulse(d);
    repeat (gap - 4) @(negedge clk);
    vs_pulse(d);
    cyc = 0;
    while (done_s[d] !== 1'b1 && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      if (toggle && rd_s[d] && addr_s[d] == 15'd100) begin
        start_s[d] = 1'b0;
        repeat (3) @(negedge clk);
        start_s[d] = 1'b1;
      end
    end
    e = sb.pop_front();
    check({tag, " done"}, int'(done_s[d]), 1);
    check({tag, " color"}, int'(color_s[d]), int'(e.color));
    check({tag, " timeout"}, int'(to_s[d]), int'(e.to));
    check({tag, " scan_rd pulses"}, scan_cnt[d] - base_cnt, n_pix);
    check({tag, " addr order errs"}, addr_err[d] - base_aerr, 0);
    check({tag, " wr_en during scan"}, wr_s[d] ? wr_err[d] - base_werr : -1, 0);
    finish_handshake(d, hold, tag);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int base_cnt;
    vecs[0]  = '{150,   0, 300, 12'h888, 2'b11, 1'b0, 0};
    vecs[1]  = '{150,   0, 100, 12'h888, 2'b00, 1'b0, 0};
    vecs[2]  = '{250, 250,   0, 12'h888, 2'b01, 1'b0, 0};
    vecs[3]  = '{  0, 300, 300, 12'h000, 2'b10, 1'b0, 0};
    vecs[4]  = '{  0, 199,   0, 12'h000, 2'b00, 1'b0, 0};
    vecs[5]  = '{  0, 200,   0, 12'h000, 2'b10, 1'b0, 0};
    vecs[6]  = '{  0,   0,   0, 12'h877, 2'b01, 1'b0, 0};
    vecs[7]  = '{  0,   0,   0, 12'h788, 2'b00, 1'b0, 0};
    vecs[8]  = '{  0,   0,   0, 12'h00F, 2'b11, 1'b1, 0};
    vecs[9]  = '{100,   0, 250, 12'h080, 2'b10, 1'b0, 20};
    vecs[10] = '{300,   0, 300, 12'h000, 2'b01, 1'b0, 0};

    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0; vsync_s[d] = 1'b0;
      n_r[d] = 0; n_g[d] = 0; n_b[d] = 0; fill[d] = 12'h000;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset cam_wr_en", int'(wr_s[d]), 1);
      check("reset busy/done/rd", int'({busy_s[d], done_s[d], rd_s[d]}), 0);
      check("reset color/timeout", int'({color_s[d], to_s[d]}), 0);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // full-size frame, all red, VSYNC pulses 1000 cycles apart
    fill[0] = 12'hF00;
    sb.push_back('{0, 2'b01, 1'b0});
    run_frame(0, 1000, 1'b0, 5, "A red");

    for (int i = 0; i < 11; i++) begin
      n_r[1] = vecs[i].n_r; n_g[1] = vecs[i].n_g; n_b[1] = vecs[i].n_b;
      fill[1] = vecs[i].fill;
      sb.push_back('{1, vecs[i].color, 1'b0});
      run_frame(1, 30, vecs[i].toggle, vecs[i].hold, $sformatf("B vec%0d", i));
    end

    // no VSYNC at all on the short-timeout instance
    sb.push_back('{1, 2'b00, 1'b1});
    base_cnt = scan_cnt[1];
    @(negedge clk);
    start_s[1] = 1'b1;
    wait_done(1, 1100, cyc);
    begin
      exp_t e;
      e = sb.pop_front();
      check("timeout done", int'(done_s[1]), 1);
      check("timeout latency in 996..1004", int'(cyc >= 996 && cyc <= 1004), 1);
      check("timeout flag", int'(to_s[1]), int'(e.to));
      check("timeout color", int'(color_s[1]), int'(e.color));
      check("timeout cam_wr_en", int'(wr_s[1]), 1);
      check("timeout no scan", scan_cnt[1] - base_cnt, 0);
    end
    finish_handshake(1, 0, "timeout");

    // reset in the middle of a full-size scan
    @(negedge clk);
    start_s[0] = 1'b1;
    repeat (5) @(negedge clk);
    vs_pulse(0);
    repeat (16) @(negedge clk);
    vs_pulse(0);
    cyc = 0;
    while (!(rd_s[0] === 1'b1 && addr_s[0] == 15'd5000) && cyc < 6000) begin
      @(negedge clk);
      cyc++;
    end
    check("reached scan_addr 5000", int'(addr_s[0]), 5000);
    rst = 1'b0;
    #1;
    check("mid-scan rst cam_wr_en", int'(wr_s[0]), 1);
    check("mid-scan rst scan_rd", int'(rd_s[0]), 0);
    check("mid-scan rst scan_addr", int'(addr_s[0]), 0);
    check("mid-scan rst busy/done", int'({busy_s[0], done_s[0]}), 0);
    check("mid-scan rst color/timeout", int'({color_s[0], to_s[0]}), 0);
    start_s[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("after rst idle", int'({busy_s[0], done_s[0]}), 0);

    fill[0] = 12'h0F0;
    sb.push_back('{0, 2'b10, 1'b0});
    run_frame(0, 20, 1'b0, 0, "A green after rst");

    check("scoreboard drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
